// File: rtl/bsg_wrr_arb_pkg.sv
// Shared types and constants for the weighted round-robin arbiter.
// A burst weight of 0 or 1 both mean "single beat".
package bsg_wrr_arb_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    HOLD = 1'b1
  } state_e;

  localparam int unsigned default_weight_lp = 1;

endpackage

// File: rtl/bsg_wrr_arb_rr_select.sv
// Rotating priority encoder: first set request at or above `start`, with wrap-around.
// Outputs are all zero when no request is set.
module bsg_wrr_arb_rr_select #(
  parameter  int inputs_p = 8,
  localparam int idx_w_lp = $clog2(inputs_p)
) (
  input  logic [inputs_p-1:0] reqs,
  input  logic [idx_w_lp-1:0] start,
  output logic [inputs_p-1:0] one_hot,
  output logic [idx_w_lp-1:0] tag,
  output logic                valid
);

  int                  pos;
  logic [idx_w_lp-1:0] idx;

  // Scan from the farthest offset down to zero so the nearest requester
  // (smallest offset from start) overwrites any farther one.
  always_comb begin
    // NOTE: every combinational output gets a default before any branch,
    // so no path leaves a value unassigned and no latch is inferred.
    one_hot = '0;
    tag     = '0;
    valid   = 1'b0;
    pos     = 0;
    idx     = '0;
    for (int i = inputs_p - 1; i >= 0; i--) begin
      pos = int'(start) + i;
      if (pos >= inputs_p) pos = pos - inputs_p;
      idx = idx_w_lp'(pos);
      if (reqs[idx]) begin
        one_hot      = '0;
        one_hot[idx] = 1'b1;
        tag          = idx;
        valid        = 1'b1;
      end
    end
  end

endmodule

// File: rtl/bsg_wrr_arb.sv
// Weighted round-robin arbiter: a winner keeps the grant for up to weight[i]
// accepted beats while it keeps requesting, then priority rotates past it.
module bsg_wrr_arb
  import bsg_wrr_arb_pkg::*;
#(
  parameter  int inputs_p       = 8,
  parameter  int weight_width_p = 4,
  localparam int idx_w_lp       = $clog2(inputs_p)
) (
  input  logic                      clk_i,
  input  logic                      reset_n_i,
  input  logic [inputs_p-1:0]       reqs_i,
  input  logic                      grants_en_i,
  output logic [inputs_p-1:0]       grants_o,
  output logic [inputs_p-1:0]       sel_one_hot_o,
  output logic [idx_w_lp-1:0]       tag_o,
  output logic                      v_o,
  input  logic                      yumi_i,
  input  logic                      cfg_v_i,
  input  logic [idx_w_lp-1:0]       cfg_idx_i,
  input  logic [weight_width_p-1:0] cfg_weight_i
);

  localparam logic [idx_w_lp-1:0]       last_idx_lp = idx_w_lp'(inputs_p - 1);
  localparam logic [weight_width_p-1:0] one_w_lp    = weight_width_p'(1);

  state_e                    state_r, state_n;
  logic [idx_w_lp-1:0]       owner_r, owner_n;
  logic [idx_w_lp-1:0]       last_r, last_n;
  logic [weight_width_p-1:0] credit_r, credit_n;
  logic [weight_width_p-1:0] weight_r [inputs_p];

  logic [idx_w_lp-1:0]       start;
  logic [inputs_p-1:0]       rr_one_hot;
  logic [idx_w_lp-1:0]       rr_tag;
  logic                      rr_valid;
  logic                      hold_sel;
  logic [weight_width_p-1:0] fresh_weight;
  logic                      fresh_single;
  logic                      accept;

  assign start = (last_r == last_idx_lp) ? '0 : last_r + idx_w_lp'(1);

  bsg_wrr_arb_rr_select #(
    .inputs_p(inputs_p)
  ) rr_select (
    .reqs   (reqs_i),
    .start  (start),
    .one_hot(rr_one_hot),
    .tag    (rr_tag),
    .valid  (rr_valid)
  );

  // The burst owner wins outright while it is still requesting.
  assign hold_sel = (state_r == HOLD) && reqs_i[owner_r];

  always_comb begin
    sel_one_hot_o = rr_one_hot;
    tag_o         = rr_tag;
    v_o           = rr_valid;
    if (hold_sel) begin
      sel_one_hot_o          = '0;
      sel_one_hot_o[owner_r] = 1'b1;
      tag_o                  = owner_r;
      v_o                    = 1'b1;
    end
  end

  assign grants_o = grants_en_i ? sel_one_hot_o : '0;

  // Weights of 0 and 1 both give a single-beat grant with no HOLD.
  assign fresh_weight = weight_r[rr_tag];
  assign fresh_single = (fresh_weight <= one_w_lp);
  assign accept       = yumi_i && v_o;

  always_comb begin
    state_n  = state_r;
    owner_n  = owner_r;
    last_n   = last_r;
    credit_n = credit_r;
    if (accept) begin
      if (hold_sel) begin
        credit_n = credit_r - one_w_lp;
        if (credit_r == one_w_lp) begin
          last_n  = owner_r;
          state_n = IDLE;
        end
      end else if (fresh_single) begin
        last_n  = rr_tag;
        state_n = IDLE;
      end else begin
        owner_n  = rr_tag;
        credit_n = fresh_weight - one_w_lp;
        state_n  = HOLD;
      end
    end else if (!yumi_i && (state_r == HOLD) && !hold_sel) begin
      // Owner dropped its request before using its credit: burst forfeited.
      last_n  = owner_r;
      state_n = IDLE;
    end
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_r  <= IDLE;
      owner_r  <= '0;
      last_r   <= last_idx_lp;
      credit_r <= '0;
      // NOTE: the weight table is reset, not left uninitialised, because the
      // arbiter must behave as plain round-robin straight out of reset.
      for (int i = 0; i < inputs_p; i++) begin
        weight_r[i] <= weight_width_p'(default_weight_lp);
      end
    end else begin
      // NOTE: state is updated with non-blocking assignments only, so every
      // register samples the pre-edge values regardless of statement order.
      state_r  <= state_n;
      owner_r  <= owner_n;
      last_r   <= last_n;
      credit_r <= credit_n;
      if (cfg_v_i && (int'(cfg_idx_i) < inputs_p)) begin
        weight_r[cfg_idx_i] <= cfg_weight_i;
      end
    end
  end

endmodule

// File: tb/tb_bsg_wrr_arb.sv
// Directed bench for bsg_wrr_arb (8 requesters, 4-bit weights).
// Inputs change just after the falling edge; outputs are checked 1 ns later.
module tb_bsg_wrr_arb;

  logic       clk_i        = 1'b0;
  logic       reset_n_i    = 1'b0;
  logic [7:0] reqs_i       = '0;
  logic       grants_en_i  = 1'b1;
  logic       yumi_i       = 1'b0;
  logic       cfg_v_i      = 1'b0;
  logic [2:0] cfg_idx_i    = '0;
  logic [3:0] cfg_weight_i = '0;
  logic [7:0] grants_o;
  logic [7:0] sel_one_hot_o;
  logic [2:0] tag_o;
  logic       v_o;

  int checks = 0;
  int errors = 0;

  bsg_wrr_arb #(
    .inputs_p      (8),
    .weight_width_p(4)
  ) dut (
    .clk_i        (clk_i),
    .reset_n_i    (reset_n_i),
    .reqs_i       (reqs_i),
    .grants_en_i  (grants_en_i),
    .grants_o     (grants_o),
    .sel_one_hot_o(sel_one_hot_o),
    .tag_o        (tag_o),
    .v_o          (v_o),
    .yumi_i       (yumi_i),
    .cfg_v_i      (cfg_v_i),
    .cfg_idx_i    (cfg_idx_i),
    .cfg_weight_i (cfg_weight_i)
  );

  always #5 clk_i = ~clk_i;

  // Accepting with nothing selected is illegal stimulus.
  always @(posedge clk_i) begin
    if (reset_n_i && yumi_i && !v_o) begin
      errors++;
      $display("FAIL yumi_without_v: v_o=%0b required 1", v_o);
    end
  end

  task automatic cycle(input logic [7:0] r, input logic y);
    @(negedge clk_i);
    cfg_v_i = 1'b0;
    reqs_i  = r;
    yumi_i  = y;
    #1;
  endtask

  task automatic write_weight(input logic [2:0] idx, input logic [3:0] w);
    @(negedge clk_i);
    yumi_i       = 1'b0;
    cfg_v_i      = 1'b1;
    cfg_idx_i    = idx;
    cfg_weight_i = w;
    #1;
  endtask

  task automatic do_reset();
    reset_n_i   = 1'b0;
    reqs_i      = '0;
    yumi_i      = 1'b0;
    cfg_v_i     = 1'b0;
    grants_en_i = 1'b1;
    repeat (2) @(negedge clk_i);
    reset_n_i = 1'b1;
  endtask

  task automatic test_reset();
    reset_n_i = 1'b0;
    reqs_i    = '0;
    #1;
    checks++;
    if ({grants_o, sel_one_hot_o, tag_o, v_o} !== 20'h0) begin
      errors++;
      $display("FAIL reset_outputs: got %h required 0", {grants_o, sel_one_hot_o, tag_o, v_o});
    end
    repeat (2) @(negedge clk_i);
    reset_n_i = 1'b1;
    #1;
    checks++;
    if ({grants_o, sel_one_hot_o, tag_o, v_o} !== 20'h0) begin
      errors++;
      $display("FAIL post_reset_idle: got %h required 0", {grants_o, sel_one_hot_o, tag_o, v_o});
    end
    cycle(8'hFF, 1'b0);
    checks++;
    if (tag_o !== 3'd0 || v_o !== 1'b1 || sel_one_hot_o !== 8'h01 || grants_o !== 8'h01) begin
      errors++;
      $display("FAIL first_favours_0: tag=%0d v=%0b sel=%h gnt=%h required 0 1 01 01",
               tag_o, v_o, sel_one_hot_o, grants_o);
    end
  endtask

  task automatic test_round_robin();
    logic [2:0] exp_tag;
    logic [7:0] exp_gnt;
    do_reset();
    for (int i = 0; i < 9; i++) begin
      cycle(8'hFF, 1'b1);
      exp_tag = 3'(i % 8);
      exp_gnt = 8'h01 << exp_tag;
      checks++;
      if (tag_o !== exp_tag || grants_o !== exp_gnt) begin
        errors++;
        $display("FAIL round_robin[%0d]: tag=%0d gnt=%h required %0d %h",
                 i, tag_o, grants_o, exp_tag, exp_gnt);
      end
    end
    yumi_i = 1'b0;
  endtask

  task automatic test_weighted_burst();
    int exp_tags [8];
    exp_tags = '{2, 2, 2, 3, 2, 2, 2, 3};
    do_reset();
    write_weight(3'd2, 4'd3);
    for (int i = 0; i < 8; i++) begin
      cycle(8'h0C, 1'b1);
      checks++;
      if (tag_o !== 3'(exp_tags[i])) begin
        errors++;
        $display("FAIL weighted_burst[%0d]: tag=%0d required %0d", i, tag_o, exp_tags[i]);
      end
    end
    yumi_i = 1'b0;
  endtask

  task automatic test_forfeit();
    int exp_tags [5];
    logic [7:0] req_seq [5];
    exp_tags = '{2, 3, 2, 2, 2};
    req_seq  = '{8'h0C, 8'h08, 8'h0C, 8'h0C, 8'h0C};
    do_reset();
    write_weight(3'd2, 4'd3);
    for (int i = 0; i < 5; i++) begin
      cycle(req_seq[i], 1'b1);
      checks++;
      if (tag_o !== 3'(exp_tags[i])) begin
        errors++;
        $display("FAIL drop_owner[%0d]: tag=%0d required %0d", i, tag_o, exp_tags[i]);
      end
    end
    cycle(8'h0C, 1'b1);
    checks++;
    if (tag_o !== 3'd3) begin
      errors++;
      $display("FAIL new_burst_end: tag=%0d required 3", tag_o);
    end
    // Owner goes quiet with no accept: burst forfeited, rotation moves past 2.
    do_reset();
    write_weight(3'd2, 4'd3);
    cycle(8'h04, 1'b1);
    cycle(8'h00, 1'b0);
    checks++;
    if (v_o !== 1'b0 || tag_o !== 3'd0) begin
      errors++;
      $display("FAIL forfeit_idle: v=%0b tag=%0d required 0 0", v_o, tag_o);
    end
    cycle(8'h06, 1'b0);
    checks++;
    if (tag_o !== 3'd1) begin
      errors++;
      $display("FAIL forfeit_rotate: tag=%0d required 1", tag_o);
    end
  endtask

  task automatic test_grants_en();
    do_reset();
    grants_en_i = 1'b0;
    cycle(8'h10, 1'b1);
    checks++;
    if (grants_o !== 8'h00 || sel_one_hot_o !== 8'h10 || tag_o !== 3'd4 || v_o !== 1'b1) begin
      errors++;
      $display("FAIL grants_disabled: gnt=%h sel=%h tag=%0d v=%0b required 00 10 4 1",
               grants_o, sel_one_hot_o, tag_o, v_o);
    end
    cycle(8'h30, 1'b0);
    grants_en_i = 1'b1;
    #1;
    checks++;
    if (tag_o !== 3'd5 || grants_o !== 8'h20) begin
      errors++;
      $display("FAIL last_after_disabled: tag=%0d gnt=%h required 5 20", tag_o, grants_o);
    end
  endtask

  task automatic test_async_reset();
    do_reset();
    write_weight(3'd2, 4'd3);
    cycle(8'h04, 1'b1);
    cycle(8'h85, 1'b0);
    checks++;
    if (tag_o !== 3'd2) begin
      errors++;
      $display("FAIL hold_before_reset: tag=%0d required 2", tag_o);
    end
    reset_n_i = 1'b0;
    #1;
    checks++;
    if (tag_o !== 3'd0 || v_o !== 1'b1) begin
      errors++;
      $display("FAIL async_reset_idle: tag=%0d v=%0b required 0 1", tag_o, v_o);
    end
    reqs_i = 8'h81;
    #1;
    checks++;
    if (tag_o !== 3'd0 || sel_one_hot_o !== 8'h01) begin
      errors++;
      $display("FAIL async_reset_81: tag=%0d sel=%h required 0 01", tag_o, sel_one_hot_o);
    end
    reset_n_i = 1'b1;
    cycle(8'h04, 1'b1);
    cycle(8'h05, 1'b0);
    checks++;
    if (tag_o !== 3'd0) begin
      errors++;
      $display("FAIL no_stale_hold: tag=%0d required 0", tag_o);
    end
  endtask

  task automatic test_cfg_midburst();
    int exp_tags [6];
    logic [7:0] req_seq [6];
    logic       yumi_seq [6];
    exp_tags = '{5, 5, 5, 0, 5, 0};
    req_seq  = '{8'h20, 8'h20, 8'h20, 8'h21, 8'h21, 8'h21};
    yumi_seq = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
    do_reset();
    write_weight(3'd5, 4'd3);
    for (int i = 0; i < 6; i++) begin
      if (i == 1) begin
        // Retune owner 5 to weight 0 while it holds credit 2.
        reqs_i = 8'h20;
        write_weight(3'd5, 4'd0);
        checks++;
        if (tag_o !== 3'd5) begin
          errors++;
          $display("FAIL cfg_during_hold: tag=%0d required 5", tag_o);
        end
      end
      cycle(req_seq[i], yumi_seq[i]);
      checks++;
      if (tag_o !== 3'(exp_tags[i])) begin
        errors++;
        $display("FAIL cfg_midburst[%0d]: tag=%0d required %0d", i, tag_o, exp_tags[i]);
      end
    end
  endtask

  initial begin
    test_reset();
    test_round_robin();
    test_weighted_burst();
    test_forfeit();
    test_grants_en();
    test_async_reset();
    test_cfg_midburst();
    @(negedge clk_i);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
